sc_tag_arbiter: RTL and testbench
=================================

Name: sc_tag_arbiter

Overview:
- Shares one wrapping sequence counter (0..TAG_MAX, wraps to 0) between NREQ requesters, issuing one tag per cycle under round-robin arbitration.
- Tracks which tags are still outstanding and stalls issue when the next tag is busy.
- Sits in front of the counter resource so that all consumers draw unique, in-order tags from a single source.

Parameters:
NREQ, 4, number of requesters (2..8)
TAG_MAX, 5, highest tag value; counter wraps TAG_MAX -> 0
TW, 3, tag width; must satisfy 2^TW > TAG_MAX

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (0 = reset)
req  in  NREQ  per-requester tag request, level, held until granted
gnt  out  NREQ  one-hot grant; combinational, same cycle as req
tag_out  out  TW  tag issued with gnt; equals current counter value
rel_vld  in  1  tag release strobe
rel_tag  in  TW  tag being released
ctr_clr  in  1  synchronous counter clear request
stall  out  1  req nonzero but no grant possible this cycle
busy  out  TAG_MAX+1  outstanding-tag bitmap (registered)
err  out  1  sticky protocol-error flag

Behaviour:
- State flops: cnt[TW-1:0], rr_ptr (index 0..NREQ-1), busy bitmap, err. All are reset to 0 asynchronously while rst=0; after reset gnt=0, stall=0, tag_out=0.
- Grant condition (combinational): grant_ok = (req != 0) & ~busy[cnt] & ~ctr_clr.
  - If grant_ok, gnt selects the first set req bit scanning from rr_ptr upward, modulo NREQ.
  - Otherwise gnt=0.
- tag_out = cnt at all times; it is meaningful only when gnt != 0.
- stall = (req != 0) & ~grant_ok.
- On a clock edge with a grant:
  - busy[cnt] <= 1.
  - cnt <= (cnt == TAG_MAX) ? 0 : cnt+1.
  - rr_ptr <= (granted index + 1) mod NREQ.
- No grant: cnt and rr_ptr hold.
- Release: on an edge with rel_vld=1 and rel_tag <= TAG_MAX with busy[rel_tag]=1, clear busy[rel_tag].
- Simultaneous release and issue of different tags: both take effect.
- Release of the tag currently at cnt: the bit clears at the edge; the grant becomes possible the following cycle, not the same cycle. No combinational bypass.
- Error: rel_vld=1 with rel_tag > TAG_MAX, or with busy[rel_tag]=0, sets err at the edge. err clears only by reset; the busy bitmap is unaffected.
- ctr_clr=1:
  - Suppresses any grant that cycle.
  - At the edge, cnt <= 0 and rr_ptr <= 0.
  - busy bits are preserved; a release arriving in the same cycle is still honoured.
  - If tag 0 is still busy afterwards, requests stall until it is released.
- Wrap-around: when all TAG_MAX+1 tags are outstanding, every request stalls. Issue resumes in order from cnt once busy[cnt] clears; tags are never reissued out of order.
- Requester dropping req without a grant is legal. Only a granted request consumes a tag.
- rst asserted mid-operation clears all state immediately; outstanding tags are forgotten.

Test Plan:
- Reset, then req=4'b0001 for 6 cycles with no release -> tag_out 0,1,2,3,4,5 granted to req0. 7th cycle: stall=1, gnt=0, busy=6'b111111.
- Continuing from full: pulse rel_vld with rel_tag=0 -> next cycle grant with tag_out=0, cnt->1, busy=6'b111111.
- After reset, req=4'b1111 held for 8 cycles, releasing each tag one cycle after issue -> gnt order 0001,0010,0100,1000,0001,...; tags 0..5 then 0,1.
- With rr_ptr=2 and req=4'b1001 -> gnt=4'b1000, next rr_ptr=0. Following cycle gnt=4'b0001.
- Issue tags 0..2, then ctr_clr=1 with req=1 -> gnt=0 that cycle; cnt=0 afterwards; stall=1 until rel_tag=0 is released, then tag_out=0 is granted.
- rel_vld with rel_tag=3 while busy[3]=0, then rel_tag=7 -> err=1 and stays 1, busy unchanged. Asserting rst=0 mid-stream -> err=0, busy=0, cnt=0 asynchronously.

Source files
------------

// File: rtl/sc_tag_arbiter.sv
// sc_tag_arbiter: round-robin arbiter that hands out unique, in-order tags
// from one wrapping counter (0..TAG_MAX) and tracks outstanding tags so a
// tag is never reissued before it has been released.
module sc_tag_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TAG_MAX = 5,
    parameter int unsigned TW      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    output logic [NREQ-1:0]    gnt,
    output logic [TW-1:0]      tag_out,
    input  logic               rel_vld,
    input  logic [TW-1:0]      rel_tag,
    input  logic               ctr_clr,
    output logic               stall,
    output logic [TAG_MAX:0]   busy,
    output logic               err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // State flops
    logic [TW-1:0]    cnt_q,  cnt_d;
    logic [PW-1:0]    rr_q,   rr_d;
    logic [TAG_MAX:0] busy_q, busy_d;
    logic             err_q,  err_d;

    // Combinational helpers
    logic             cur_busy;
    logic             any_req;
    logic             grant_ok;
    logic             found;
    logic [PW-1:0]    gidx;
    logic [NREQ-1:0]  gnt_c;
    logic             rel_in_range;
    logic             rel_hit;
    logic             rel_ok;

    // Look up whether the tag the counter currently points at is outstanding
    always_comb begin
        cur_busy = 1'b0;
        for (int unsigned i = 0; i <= TAG_MAX; i++) begin
            if (cnt_q == TW'(i)) begin
                cur_busy = busy_q[i];
            end
        end
    end

    // Round-robin pick: first asserted request scanning upward from rr_q
    always_comb begin
        any_req  = |req;
        grant_ok = any_req & ~cur_busy & ~ctr_clr;
        found    = 1'b0;
        gidx     = '0;
        gnt_c    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && ((32'(rr_q) + k) % NREQ == j) && req[j]) begin
                    found    = 1'b1;
                    gidx     = PW'(j);
                    gnt_c[j] = grant_ok;
                end
            end
        end
    end

    // Qualify the release strobe: tag must be in range and outstanding
    always_comb begin
        rel_in_range = (32'(rel_tag) <= TAG_MAX);
        rel_hit      = 1'b0;
        for (int unsigned i = 0; i <= TAG_MAX; i++) begin
            if (rel_tag == TW'(i)) begin
                rel_hit = busy_q[i];
            end
        end
        rel_ok = rel_vld & rel_in_range & rel_hit;
    end

    // Next-state: issue, counter clear, release and sticky error
    always_comb begin
        cnt_d  = cnt_q;
        rr_d   = rr_q;
        busy_d = busy_q;
        err_d  = err_q;

        if (grant_ok) begin
            for (int unsigned i = 0; i <= TAG_MAX; i++) begin
                if (cnt_q == TW'(i)) begin
                    busy_d[i] = 1'b1;
                end
            end
            cnt_d = (cnt_q == TW'(TAG_MAX)) ? '0 : cnt_q + TW'(1);
            rr_d  = (32'(gidx) + 1 == NREQ) ? '0 : gidx + PW'(1);
        end

        // Clear only rewinds the counter and pointer; outstanding tags stay tracked
        if (ctr_clr) begin
            cnt_d = '0;
            rr_d  = '0;
        end

        // Released tag can never equal the issued one (issue needs it idle)
        if (rel_ok) begin
            for (int unsigned i = 0; i <= TAG_MAX; i++) begin
                if (rel_tag == TW'(i)) begin
                    busy_d[i] = 1'b0;
                end
            end
        end

        if (rel_vld && !rel_ok) begin
            err_d = 1'b1;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            rr_q   <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign gnt     = gnt_c;
    assign tag_out = cnt_q;
    assign stall   = any_req & ~grant_ok;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sc_tag_arbiter.sv
// Bench for sc_tag_arbiter: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_sc_tag_arbiter;

    localparam int NREQ    = 4;
    localparam int TAG_MAX = 5;
    localparam int TW      = 3;
    localparam int NTAG    = TAG_MAX + 1;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic [NREQ-1:0]  req     = '0;
    logic [NREQ-1:0]  gnt;
    logic [TW-1:0]    tag_out;
    logic             rel_vld = 1'b0;
    logic [TW-1:0]    rel_tag = '0;
    logic             ctr_clr = 1'b0;
    logic             stall;
    logic [TAG_MAX:0] busy;
    logic             err;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_cnt = 0;
    int m_rr  = 0;
    int m_err = 0;
    int m_busy [NTAG];

    always #5 clk = ~clk;

    sc_tag_arbiter #(
        .NREQ    (NREQ),
        .TAG_MAX (TAG_MAX),
        .TW      (TW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .tag_out (tag_out),
        .rel_vld (rel_vld),
        .rel_tag (rel_tag),
        .ctr_clr (ctr_clr),
        .stall   (stall),
        .busy    (busy),
        .err     (err)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Index of the requester that must be granted now, or -1
    function automatic int model_pick();
        int idx;
        if (req == '0 || m_busy[m_cnt] != 0 || ctr_clr) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int busy_vec();
        int v = 0;
        for (int i = 0; i < NTAG; i++) v += m_busy[i] << i;
        return v;
    endfunction

    // Model update on each clock edge / asynchronous reset
    always @(posedge clk or negedge rst) begin
        int g;
        int rok;
        int rt;
        if (!rst) begin
            m_cnt = 0;
            m_rr  = 0;
            m_err = 0;
            for (int i = 0; i < NTAG; i++) m_busy[i] = 0;
        end else begin
            g   = model_pick();
            rt  = int'(rel_tag);
            rok = (rel_vld && rt < NTAG && m_busy[rt] != 0) ? 1 : 0;
            if (rel_vld && rok == 0) m_err = 1;
            if (g >= 0) begin
                m_busy[m_cnt] = 1;
                m_cnt = (m_cnt + 1) % NTAG;
                m_rr  = (g + 1) % NREQ;
            end
            if (ctr_clr) begin
                m_cnt = 0;
                m_rr  = 0;
            end
            if (rok != 0) m_busy[rt] = 0;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        int g;
        int eg;
        g  = model_pick();
        eg = (g < 0) ? 0 : (1 << g);
        check("gnt",     int'(gnt),     eg);
        check("tag_out", int'(tag_out), m_cnt);
        check("stall",   int'(stall),   (req != '0 && g < 0) ? 1 : 0);
        check("busy",    int'(busy),    busy_vec());
        check("err",     int'(err),     m_err);
    end

    task automatic apply(input logic [NREQ-1:0] r, input logic rv,
                         input logic [TW-1:0] rt, input logic cc);
        @(posedge clk);
        #1;
        req     = r;
        rel_vld = rv;
        rel_tag = rt;
        ctr_clr = cc;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        apply('0, 1'b0, '0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] r;
        logic            rv;
        logic [TW-1:0]   rt;
        logic            cc;
        int              x;

        // Reset state
        apply('0, 1'b0, '0, 1'b0);
        check("rst_gnt",   int'(gnt),     0);
        check("rst_stall", int'(stall),   0);
        check("rst_tag",   int'(tag_out), 0);
        check("rst_busy",  int'(busy),    0);
        check("rst_err",   int'(err),     0);
        rst = 1'b1;

        // Single requester drains all six tags, then stalls
        for (int k = 0; k < 6; k++) begin
            apply(4'b0001, 1'b0, '0, 1'b0);
            check("fill_gnt", int'(gnt),     1);
            check("fill_tag", int'(tag_out), k);
        end
        apply(4'b0001, 1'b0, '0, 1'b0);
        check("full_stall", int'(stall), 1);
        check("full_gnt",   int'(gnt),   0);
        check("full_busy",  int'(busy),  6'b111111);

        // Releasing tag 0 allows a grant only on the following cycle
        apply(4'b0001, 1'b1, 3'd0, 1'b0);
        check("relsame_stall", int'(stall), 1);
        apply(4'b0001, 1'b0, '0, 1'b0);
        check("reissue_gnt", int'(gnt),     1);
        check("reissue_tag", int'(tag_out), 0);
        apply('0, 1'b0, '0, 1'b0);
        check("reissue_cnt",  int'(tag_out), 1);
        check("reissue_busy", int'(busy),    6'b111111);

        // All requesters, each tag released one cycle after issue
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(4'b1111, (i > 0), TW'((i + 5) % 6), 1'b0);
            check("rr_gnt", int'(gnt),     1 << (i % 4));
            check("rr_tag", int'(tag_out), i % 6);
        end

        // Pointer at 2 with req 1001 wraps to requester 3 then 0
        do_reset();
        apply(4'b0001, 1'b0, '0, 1'b0);
        check("ptr_g0", int'(gnt), 4'b0001);
        apply(4'b0010, 1'b0, '0, 1'b0);
        check("ptr_g1", int'(gnt), 4'b0010);
        apply(4'b1001, 1'b0, '0, 1'b0);
        check("ptr_g3", int'(gnt), 4'b1000);
        apply(4'b1001, 1'b0, '0, 1'b0);
        check("ptr_wrap", int'(gnt), 4'b0001);

        // Counter clear with tag 0 still outstanding
        do_reset();
        for (int k = 0; k < 3; k++) apply(4'b0001, 1'b0, '0, 1'b0);
        apply(4'b0001, 1'b0, '0, 1'b1);
        check("clr_gnt",   int'(gnt),     0);
        check("clr_stall", int'(stall),   1);
        check("clr_tag",   int'(tag_out), 3);
        apply(4'b0001, 1'b0, '0, 1'b0);
        check("clr_cnt0",   int'(tag_out), 0);
        check("clr_stall2", int'(stall),   1);
        apply(4'b0001, 1'b1, 3'd0, 1'b0);
        check("clr_stall3", int'(stall), 1);
        apply(4'b0001, 1'b0, '0, 1'b0);
        check("clr_regnt", int'(gnt),     1);
        check("clr_retag", int'(tag_out), 0);

        // Protocol errors are sticky and leave busy untouched
        do_reset();
        apply(4'b0001, 1'b0, '0, 1'b0);
        apply(4'b0001, 1'b0, '0, 1'b0);
        apply('0, 1'b1, 3'd3, 1'b0);
        check("err_pre", int'(err), 0);
        apply('0, 1'b1, 3'd7, 1'b0);
        check("err_set", int'(err), 1);
        apply('0, 1'b0, '0, 1'b0);
        check("err_hold", int'(err),  1);
        check("err_busy", int'(busy), 6'b000011);
        rst = 1'b0;
        #1;
        check("arst_err",  int'(err),     0);
        check("arst_busy", int'(busy),    0);
        check("arst_tag",  int'(tag_out), 0);
        apply('0, 1'b0, '0, 1'b0);
        rst = 1'b1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r  = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) r = '0;
            rv = ($urandom_range(0, 2) == 0);
            x  = $urandom_range(0, 19);
            rt = (x < 18) ? TW'(x % 6) : TW'(x - 12);
            cc = ($urandom_range(0, 24) == 0);
            apply(r, rv, rt, cc);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                rst = 1'b1;
            end
        end

        apply('0, 1'b0, '0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
